// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

   localparam int PORT_LOADER = 0;
   localparam int PORT_CPU    = 1;

   // Counter width for the default timeout; the arbiter derives its own from TIMEOUT.
   localparam int TIMEOUT_DEFAULT = 255;
   localparam int TO_WIDTH        = $clog2(TIMEOUT_DEFAULT + 1);

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing mem_ctl between the UART loader (port 0) and the CPU (port 1).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 25,
   parameter int DATA_WIDTH = 16,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req,
   input  logic                  we0,
   input  logic                  we1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic [1:0]            ack,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_start,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_busy,
   input  logic                  mem_done,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_e                state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  last_q, last_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [TW-1:0]         cnt_q, cnt_d;

   // A lone requester wins; on a tie the port that was not served last wins.
   function automatic logic rr_pick(input logic [1:0] r, input logic last);
      if (r == 2'b11) return ~last;
      return r[1];
   endfunction

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      mem_start = 1'b0;
      ack       = 2'b00;
      case (state_q)
         IDLE: if (|req) begin
            grant_d = rr_pick(req, last_q);
            we_d    = grant_d ? we1    : we0;
            addr_d  = grant_d ? addr1  : addr0;
            wdata_d = grant_d ? wdata1 : wdata0;
            state_d = ISSUE;
         end
         ISSUE: if (!mem_busy) begin
            mem_start = 1'b1;
            cnt_d     = '0;
            state_d   = WAIT;
         end
         WAIT: begin
            // mem_done takes priority over a timeout landing in the same cycle.
            if (mem_done) begin
               rdata_d = mem_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            if (grant_q) ack[PORT_CPU] = 1'b1;
            else         ack[PORT_LOADER] = 1'b1;
            last_d  = grant_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a transaction-level model with a memory emulator.
module tb_mem_arbiter;

   localparam int AW = 25;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic [1:0]    ack;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic          mem_start, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_busy, mem_done;
   logic [DW-1:0] mem_rdata;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;
   int mdl_last;
   logic [DW-1:0] mdl_mem [256];
   logic [DW-1:0] emu_mem [256];

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .req(req), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack(ack), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_start(mem_start), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_busy(mem_busy), .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One whole transaction starting in IDLE with req already applied; the emulated
   // controller stalls busy_cyc cycles and answers done_dly cycles into WAIT.
   task automatic txn(input int busy_cyc, input int done_dly, input string tag);
      int            port;
      int            w_end;
      logic          exp_we;
      logic [AW-1:0] exp_a;
      logic [DW-1:0] exp_wd, rd, exp_rd;
      bit            exp_err;
      port    = (req == 2'b11) ? 1 - mdl_last : (req[1] ? 1 : 0);
      exp_we  = port ? we1 : we0;
      exp_a   = port ? addr1 : addr0;
      exp_wd  = port ? wdata1 : wdata0;
      exp_err = done_dly > TO - 1;
      w_end   = exp_err ? TO - 1 : done_dly;
      mem_busy = busy_cyc > 0;
      step();
      chk({tag, ".addr"}, mem_addr, exp_a);
      chk({tag, ".we"}, mem_we, exp_we);
      if (exp_we) chk({tag, ".wdata"}, mem_wdata, exp_wd);
      chk({tag, ".busy"}, busy, 1);
      for (int i = 0; i < busy_cyc; i++) begin
         chk({tag, ".start_stall"}, mem_start, 0);
         step();
      end
      mem_busy = 1'b0;
      #1;
      chk({tag, ".start"}, mem_start, 1);
      step();
      chk({tag, ".start_pulse"}, mem_start, 0);
      rd = '0;
      for (int w = 0; w <= w_end; w++) begin
         if (w == done_dly) begin
            mem_done = 1'b1;
            if (mem_we) begin
               rd = DW'($urandom);
               emu_mem[mem_addr[7:0]] = mem_wdata;
            end else begin
               rd = emu_mem[mem_addr[7:0]];
            end
            mem_rdata = rd;
         end
         chk({tag, ".ack_wait"}, ack, 0);
         step();
         mem_done  = 1'b0;
         mem_rdata = DW'($urandom);
      end
      exp_rd = exp_err ? '0 : (exp_we ? rd : mdl_mem[exp_a[7:0]]);
      chk({tag, ".ack"}, ack, port ? 2'b10 : 2'b01);
      chk({tag, ".rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".err"}, rsp_err, exp_err);
      if (!exp_err && exp_we) mdl_mem[exp_a[7:0]] = exp_wd;
      mdl_last  = port;
      req[port] = 1'b0;
      step();
      chk({tag, ".ack_once"}, ack, 0);
      chk({tag, ".idle"}, busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mdl_mem[i] = '0;
         emu_mem[i] = '0;
      end
      rst = 1'b1; req = 2'b00; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; mem_busy = 0; mem_done = 0; mem_rdata = '0;
      mdl_last = 1;
      repeat (3) step();
      chk("rst.ack", ack, 0);
      chk("rst.start", mem_start, 0);
      chk("rst.busy", busy, 0);
      chk("rst.addr", mem_addr, 0);
      chk("rst.we", mem_we, 0);
      chk("rst.wdata", mem_wdata, 0);
      chk("rst.rdata", rsp_rdata, 0);
      chk("rst.err", rsp_err, 0);

      // Tie on the first cycle after reset: loader first, then CPU.
      rst = 1'b0;
      we0 = 1; addr0 = 25'h10; wdata0 = 16'h1111;
      we1 = 0; addr1 = 25'h20;
      req = 2'b11;
      txn(0, 1, "t2a");
      txn(0, 1, "t2b");

      // CPU read answered on the second WAIT cycle.
      emu_mem[8'h23] = 16'hABCD; mdl_mem[8'h23] = 16'hABCD;
      we1 = 0; addr1 = 25'h0000123; req = 2'b10;
      txn(0, 1, "t1");

      // Both ports continuously requesting alternate.
      we0 = 1; addr0 = 25'h31; wdata0 = 16'h5A5A;
      we1 = 0; addr1 = 25'h31;
      for (int k = 0; k < 6; k++) begin
         req = 2'b11;
         txn(0, 0, "t3");
      end
      req = 2'b00;

      // Controller busy for five cycles.
      we0 = 0; addr0 = 25'h31; req = 2'b01;
      txn(5, 1, "t4");

      // Timeout, then normal service, then done on the last allowed cycle.
      we1 = 0; addr1 = 25'h23; req = 2'b10;
      txn(0, 20, "t5.to");
      req = 2'b10;
      txn(0, 0, "t5.next");
      req = 2'b10;
      txn(0, TO - 1, "t5.edge");

      // Reset during WAIT aborts silently and restores the tie preference.
      we0 = 1; addr0 = 25'h40; wdata0 = 16'h2222; req = 2'b01;
      txn(0, 0, "t6a");
      req = 2'b01;
      step();
      step();
      chk("t6.inwait", busy, 1);
      rst = 1'b1; req = 2'b00;
      step();
      rst = 1'b0; mem_done = 1'b1; mem_rdata = 16'hDEAD;
      mdl_last = 1;
      chk("t6.ack_rst", ack, 0);
      chk("t6.busy_rst", busy, 0);
      chk("t6.addr_rst", mem_addr, 0);
      step();
      mem_done = 1'b0;
      chk("t6.stale_ack", ack, 0);
      chk("t6.stale_busy", busy, 0);
      we0 = 0; addr0 = 25'h40; we1 = 0; addr1 = 25'h20; req = 2'b11;
      txn(0, 0, "t6.tie");
      req = 2'b00;

      // Randomized traffic; a requester keeps its fields until it is served.
      for (int n = 0; n < 40; n++) begin
         if (!req[0] && ($urandom % 2 == 1)) begin
            req[0] = 1'b1; we0 = 1'($urandom); addr0 = {17'($urandom), 8'($urandom % 32)};
            wdata0 = DW'($urandom);
         end
         if (!req[1] && ($urandom % 2 == 1)) begin
            req[1] = 1'b1; we1 = 1'($urandom); addr1 = {17'($urandom), 8'($urandom % 32)};
            wdata1 = DW'($urandom);
         end
         if (req == 2'b00) begin
            req[0] = 1'b1; we0 = 1'b0; addr0 = 25'($urandom % 32);
         end
         txn(int'($urandom % 4), int'($urandom % 11), "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
